// File: rtl/axi_write_responder_pkg.sv
// Shared AXI helpers for the write responder: bus-width functions, burst/response
// encodings and the responder state type.
package axi_write_responder_pkg;

    function automatic int calculate_AXI_OFFSET_W(input int dataW);
        return $clog2(dataW / 8);
    endfunction

    function automatic int calculate_AXI_AXSIZE(input int dataW);
        return $clog2(dataW / 8);
    endfunction

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } wrState_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address generator for AXI FIXED/INCR bursts with 4KB and size checking.
// Loaded on the address handshake, stepped on every accepted data beat.
module axi_burst_addr_gen
    import axi_write_responder_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 2,
    parameter int MAX_SIZE = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_i,
    input  logic                       step_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [7:0]                 len_i,
    input  logic [2:0]                 size_i,
    input  logic [1:0]                 burst_i,
    output logic [ADDR_W-OFFSET_W-1:0] wordAddr_o,
    output logic                       lastBeat_o,
    output logic                       cfgErr_o
);

    logic [ADDR_W-1:0] beatAddr_q;
    logic [7:0]        cnt_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              cfgErr_q;

    logic [11:0]       alignedOff;
    logic [20:0]       burstBytes;
    logic [20:0]       endOffset;
    logic [ADDR_W-1:0] alignedBeat;
    logic              cfgErr_d;

    // Only the offset inside the 4KB page matters for the boundary check.
    always_comb begin
        alignedOff  = addr_i[11:0] & ~((12'd1 << size_i) - 12'd1);
        burstBytes  = (21'(len_i) + 21'd1) << size_i;
        endOffset   = 21'(alignedOff) + burstBytes;
        alignedBeat = beatAddr_q & ~((ADDR_W'(1) << size_q) - ADDR_W'(1));
        cfgErr_d    = 1'b0;
        if (burst_i == AXI_BURST_WRAP || burst_i == 2'b11) begin
            cfgErr_d = 1'b1;
        end
        if (size_i > 3'(MAX_SIZE)) begin
            cfgErr_d = 1'b1;
        end
        if (burst_i == AXI_BURST_INCR && endOffset > 21'd4096) begin
            cfgErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beatAddr_q <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            cfgErr_q   <= 1'b0;
        end else if (load_i) begin
            beatAddr_q <= addr_i;
            cnt_q      <= '0;
            len_q      <= len_i;
            size_q     <= size_i;
            burst_q    <= burst_i;
            cfgErr_q   <= cfgErr_d;
        end else if (step_i) begin
            if (cnt_q != len_q) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (burst_q == AXI_BURST_INCR) begin
                beatAddr_q <= alignedBeat + (ADDR_W'(1) << size_q);
            end
        end
    end

    assign wordAddr_o = beatAddr_q[ADDR_W-1:OFFSET_W];
    assign lastBeat_o = (cnt_q == len_q);
    assign cfgErr_o   = cfgErr_q;

endmodule

// File: rtl/axi_write_responder.sv
// AXI4 write-channel responder: turns AW/W bursts into word-wide memory writes
// and returns one B response per burst, flagging bad burst parameters as SLVERR.
module axi_write_responder
    import axi_write_responder_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int MEM_ADDR_W = AXI_ADDR_W - calculate_AXI_OFFSET_W(AXI_DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AXI_ID_W-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [AXI_ID_W-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic                    mem_valid,
    output logic [MEM_ADDR_W-1:0]   mem_addr,
    output logic [AXI_DATA_W-1:0]   mem_wdata,
    output logic [AXI_DATA_W/8-1:0] mem_wstrb,
    input  logic                    mem_ready
);

    localparam int OFFSET_W = calculate_AXI_OFFSET_W(AXI_DATA_W);
    localparam int MAX_SIZE = calculate_AXI_AXSIZE(AXI_DATA_W);

    wrState_t              state_q;
    logic                  awready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [AXI_ID_W-1:0]   bid_q;
    logic                  errLast_q;

    logic                  awAccept;
    logic                  beatAccept;
    logic                  inData;
    logic                  lastBeat;
    logic                  cfgErr;
    logic                  wlastErr;

    axi_burst_addr_gen #(
        .ADDR_W   (AXI_ADDR_W),
        .OFFSET_W (OFFSET_W),
        .MAX_SIZE (MAX_SIZE)
    ) u_addrGen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (awAccept),
        .step_i     (beatAccept),
        .addr_i     (s_axi_awaddr),
        .len_i      (s_axi_awlen),
        .size_i     (s_axi_awsize),
        .burst_i    (s_axi_awburst),
        .wordAddr_o (mem_addr),
        .lastBeat_o (lastBeat),
        .cfgErr_o   (cfgErr)
    );

    // Errored bursts drain at full rate without touching memory.
    assign inData     = (state_q == ST_DATA);
    assign awAccept   = s_axi_awvalid & awready_q;
    assign s_axi_wready = inData & (cfgErr | mem_ready);
    assign beatAccept = s_axi_wvalid & s_axi_wready;
    assign wlastErr   = s_axi_wlast ^ lastBeat;
    assign mem_valid  = inData & s_axi_wvalid & ~cfgErr;
    assign mem_wdata  = s_axi_wdata;
    assign mem_wstrb  = s_axi_wstrb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            bid_q     <= '0;
            errLast_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (awAccept) begin
                        awready_q <= 1'b0;
                        bid_q     <= s_axi_awid;
                        errLast_q <= 1'b0;
                        state_q   <= ST_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (beatAccept) begin
                        if (wlastErr) begin
                            errLast_q <= 1'b1;
                        end
                        if (lastBeat) begin
                            state_q  <= ST_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (cfgErr | errLast_q | wlastErr) ? AXI_RESP_SLVERR
                                                                        : AXI_RESP_OKAY;
                        end
                    end
                end
                ST_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;

endmodule

// File: tb/tb_axi_write_responder.sv
// Directed self-checking bench for axi_write_responder: a burst-level model predicts
// every memory write and B response, and a negedge monitor checks them.
module tb_axi_write_responder;
    import axi_write_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic        mem_valid;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [29:0] expAddrQ[$];
    logic [31:0] expDataQ[$];
    logic [3:0]  expStrbQ[$];
    logic [3:0]  expBidQ[$];
    logic [1:0]  expBrespQ[$];
    logic [29:0] logAddr[$];
    logic [3:0]  logStrb[$];
    int          logCyc[$];
    logic [31:0] beatData[256];
    logic [1:0]  lastBresp;
    logic [3:0]  lastBid;
    int          bCount = 0;

    axi_write_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string detail);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Every memory write and every B handshake is matched against the model queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_valid && mem_ready) begin
                logAddr.push_back(mem_addr);
                logStrb.push_back(mem_wstrb);
                logCyc.push_back(cycle);
                if (expAddrQ.size() == 0) begin
                    reportFail("unexpectedWrite", $sformatf("got write to 0x%0h, expected none", mem_addr));
                end else begin
                    checkOutput("memAddr", mem_addr, expAddrQ.pop_front());
                    checkOutput("memWdata", mem_wdata, expDataQ.pop_front());
                    checkOutput("memWstrb", mem_wstrb, expStrbQ.pop_front());
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                lastBresp = s_axi_bresp;
                lastBid   = s_axi_bid;
                bCount++;
                if (expBidQ.size() == 0) begin
                    reportFail("unexpectedB", $sformatf("got bresp %0d, expected no response", s_axi_bresp));
                end else begin
                    checkOutput("bid", s_axi_bid, expBidQ.pop_front());
                    checkOutput("bresp", s_axi_bresp, expBrespQ.pop_front());
                end
            end
        end
    end

    // Burst-level model: byte address of each beat from the AXI rules, then word address.
    task automatic modelBurst(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                              input logic [1:0] burst, input int lastIdx, input logic [3:0] strb,
                              input int abortAfter, output bit cfgErr);
        longint beatBytes;
        longint base;
        longint aligned;
        longint byteAddr;
        int     nBeats;
        beatBytes = longint'(1) << size;
        base      = longint'(addr);
        aligned   = base - (base % beatBytes);
        cfgErr    = (burst == 2'b10) || (burst == 2'b11) || (size > 2) ||
                    ((burst == 2'b01) && ((aligned % 4096) + longint'(len + 1) * beatBytes > 4096));
        nBeats    = (abortAfter >= 0) ? abortAfter : len + 1;
        for (int i = 0; i < nBeats; i++) begin
            byteAddr = (burst == 2'b00 || i == 0) ? base : aligned + longint'(i) * beatBytes;
            if (!cfgErr) begin
                expAddrQ.push_back(30'(byteAddr >> 2));
                expDataQ.push_back(beatData[i]);
                expStrbQ.push_back(strb);
            end
        end
        if (abortAfter < 0) begin
            expBidQ.push_back(id);
            expBrespQ.push_back((cfgErr || lastIdx != len) ? 2'b10 : 2'b00);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_awready"}, s_axi_awready, 1'b0);
        checkOutput({tag, "_wready"}, s_axi_wready, 1'b0);
        checkOutput({tag, "_bvalid"}, s_axi_bvalid, 1'b0);
        checkOutput({tag, "_memValid"}, mem_valid, 1'b0);
        checkOutput({tag, "_bresp"}, s_axi_bresp, 2'b00);
        checkOutput({tag, "_bid"}, s_axi_bid, 4'h0);
        checkOutput({tag, "_memAddr"}, mem_addr, 30'h0);
    endtask

    task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                                 input logic [1:0] burst, input int lastIdx, input logic [3:0] strb,
                                 input bit toggleReady, input int bDelay, input int abortAfter);
        bit         cfgErr;
        bit         acc;
        int         beat;
        int         cyc;
        int         guard;
        logic [1:0] expResp;
        for (int i = 0; i <= len; i++) beatData[i] = $urandom;
        modelBurst(id, addr, len, size, burst, lastIdx, strb, abortAfter, cfgErr);
        expResp = (cfgErr || lastIdx != len) ? 2'b10 : 2'b00;
        logAddr.delete();
        logStrb.delete();
        logCyc.delete();
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b1;
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awsize  = 3'(size);
        s_axi_awburst = burst;
        guard = 0;
        forever begin
            @(negedge clk);
            if (s_axi_awready) break;
            guard++;
            if (guard > 20) begin
                reportFail("awTimeout", "awready never rose, expected within 20 cycles");
                s_axi_awvalid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= len) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = beatData[beat];
            s_axi_wstrb  = strb;
            s_axi_wlast  = (beat == lastIdx);
            mem_ready    = toggleReady ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            checkOutput("wready", s_axi_wready, cfgErr ? 1'b1 : mem_ready);
            acc = s_axi_wready;
            @(posedge clk);
            #1;
            if (acc) beat++;
            cyc++;
            if (abortAfter >= 0 && beat == abortAfter) begin
                rst_n        = 1'b0;
                s_axi_wvalid = 1'b0;
                s_axi_wlast  = 1'b0;
                #1;
                checkResetOutputs("abortReset");
                return;
            end
            if (cyc > 600) begin
                reportFail("wTimeout", $sformatf("only %0d of %0d beats accepted", beat, len + 1));
                break;
            end
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        mem_ready    = 1'b1;
        if (bDelay > 0) s_axi_bready = 1'b0;
        guard = 0;
        forever begin
            @(negedge clk);
            if (s_axi_bvalid) break;
            guard++;
            if (guard > 20) begin
                reportFail("bTimeout", "bvalid never rose, expected within 20 cycles");
                s_axi_bready = 1'b1;
                return;
            end
        end
        for (int d = 0; d < bDelay; d++) begin
            checkOutput("bvalidHeld", s_axi_bvalid, 1'b1);
            checkOutput("brespHeld", s_axi_bresp, expResp);
            @(negedge clk);
        end
        if (bDelay > 0) begin
            @(posedge clk);
            #1;
            s_axi_bready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axi_awid    = '0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_awsize  = '0;
        s_axi_awburst = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wlast   = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        mem_ready     = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("awreadyAfterReset", s_axi_awready, 1'b0);
        @(negedge clk);
        checkOutput("awreadyRises", s_axi_awready, 1'b1);

        $display("[TB] INCR 0x100 len 3, held B for 2 cycles");
        applyStimulus(4'd5, 32'h100, 3, 2, AXI_BURST_INCR, 3, 4'hF, 1'b0, 2, -1);
        checkOutput("t1Writes", logAddr.size(), 4);
        if (logAddr.size() == 4) begin
            checkOutput("t1Addr0", logAddr[0], 30'h40);
            checkOutput("t1Addr3", logAddr[3], 30'h43);
            checkOutput("t1BackToBack", logCyc[3] - logCyc[0], 3);
        end
        checkOutput("t1Bid", lastBid, 4'd5);
        checkOutput("t1Bresp", lastBresp, 2'b00);

        $display("[TB] unaligned INCR 0x102 len 1");
        applyStimulus(4'd2, 32'h102, 1, 2, AXI_BURST_INCR, 1, 4'hA, 1'b0, 0, -1);
        checkOutput("t2Writes", logAddr.size(), 2);
        if (logAddr.size() == 2) begin
            checkOutput("t2Addr0", logAddr[0], 30'h40);
            checkOutput("t2Addr1", logAddr[1], 30'h41);
            checkOutput("t2Strb", logStrb[1], 4'hA);
        end

        $display("[TB] INCR 0xFF8 crossing 4KB");
        applyStimulus(4'd3, 32'hFF8, 3, 2, AXI_BURST_INCR, 3, 4'hF, 1'b0, 0, -1);
        checkOutput("t3Writes", logAddr.size(), 0);
        checkOutput("t3Bresp", lastBresp, 2'b10);

        $display("[TB] INCR 0xFF0 ending exactly on 4KB");
        applyStimulus(4'd4, 32'hFF0, 3, 2, AXI_BURST_INCR, 3, 4'hF, 1'b0, 0, -1);
        checkOutput("t4Bresp", lastBresp, 2'b00);

        $display("[TB] FIXED 0x20 len 2");
        applyStimulus(4'd6, 32'h20, 2, 2, AXI_BURST_FIXED, 2, 4'h3, 1'b0, 0, -1);
        checkOutput("t5Writes", logAddr.size(), 3);
        if (logAddr.size() == 3) checkOutput("t5Addr2", logAddr[2], 30'h08);
        checkOutput("t5Bresp", lastBresp, 2'b00);

        $display("[TB] early wlast on beat 1 of len 3");
        applyStimulus(4'd7, 32'h200, 3, 2, AXI_BURST_INCR, 1, 4'hF, 1'b0, 0, -1);
        checkOutput("t6Writes", logAddr.size(), 4);
        checkOutput("t6Bresp", lastBresp, 2'b10);

        $display("[TB] early wlast with mem_ready toggling");
        applyStimulus(4'd8, 32'h200, 3, 2, AXI_BURST_INCR, 1, 4'hF, 1'b1, 0, -1);
        checkOutput("t7Writes", logAddr.size(), 4);
        checkOutput("t7Bresp", lastBresp, 2'b10);

        $display("[TB] WRAP and oversize bursts");
        applyStimulus(4'd9, 32'h40, 3, 2, AXI_BURST_WRAP, 3, 4'hF, 1'b0, 0, -1);
        checkOutput("t8Bresp", lastBresp, 2'b10);
        applyStimulus(4'd10, 32'h40, 1, 3, AXI_BURST_INCR, 1, 4'hF, 1'b0, 0, -1);
        checkOutput("t9Writes", logAddr.size(), 0);

        $display("[TB] 256-beat INCR burst");
        applyStimulus(4'd11, 32'h0, 255, 2, AXI_BURST_INCR, 255, 4'hF, 1'b0, 0, -1);
        checkOutput("t10Writes", logAddr.size(), 256);
        if (logAddr.size() == 256) checkOutput("t10AddrLast", logAddr[255], 30'hFF);
        checkOutput("t10Bresp", lastBresp, 2'b00);

        $display("[TB] reset during len 7 burst");
        bCount = 0;
        applyStimulus(4'd12, 32'h400, 7, 2, AXI_BURST_INCR, 7, 4'hF, 1'b0, 0, 2);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'd13, 32'h300, 0, 2, AXI_BURST_INCR, 0, 4'hF, 1'b0, 0, -1);
        checkOutput("t11Writes", logAddr.size(), 1);
        if (logAddr.size() == 1) checkOutput("t11Addr", logAddr[0], 30'hC0);
        checkOutput("t11BCount", bCount, 1);
        checkOutput("t11Bid", lastBid, 4'd13);
        checkOutput("t11Bresp", lastBresp, 2'b00);

        repeat (3) @(posedge clk);
        checkOutput("pendingWrites", expAddrQ.size(), 0);
        checkOutput("pendingB", expBidQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_write_responder.md
Name: axi_write_responder

Overview:
- AXI4 write-channel subordinate (responder). It accepts AW/W bursts issued by Versat AXI masters or a testbench, and converts each beat into a word-wide memory write strobe.
- Returns one B response per burst.
- It is the receiving end of the burst parameters the master side computes (AxLEN, AxSIZE, 4K rule, alignment). It checks those parameters rather than generating them.
- Used behind the interconnect as the external-memory model and as the target for on-chip scratch RAM.

Parameters:
- AXI_ADDR_W, 32, byte address width.
- AXI_DATA_W, 32, data bus width; power of 2, 8..1024.
- AXI_ID_W, 4, transaction ID width.
- MEM_ADDR_W, AXI_ADDR_W-OFFSET_W, word address width of the memory port. OFFSET_W = calculate_AXI_OFFSET_W(AXI_DATA_W).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- s_axi_awid  in  AXI_ID_W  write ID
- s_axi_awaddr  in  AXI_ADDR_W  burst start byte address
- s_axi_awlen  in  8  beats-1
- s_axi_awsize  in  3  log2 bytes per beat
- s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- s_axi_awvalid  in  1 / s_axi_awready  out  1
- s_axi_wdata  in  AXI_DATA_W
- s_axi_wstrb  in  AXI_DATA_W/8
- s_axi_wlast  in  1
- s_axi_wvalid  in  1 / s_axi_wready  out  1
- s_axi_bid  out  AXI_ID_W
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_bvalid  out  1 / s_axi_bready  in  1
- mem_valid  out  1  write request
- mem_addr  out  MEM_ADDR_W  word address
- mem_wdata  out  AXI_DATA_W
- mem_wstrb  out  AXI_DATA_W/8
- mem_ready  in  1  memory accepts the write this cycle

Behaviour:

Reset:
- State is IDLE.
- awready, wready, bvalid and mem_valid are all 0 while rst_n is low.
- bresp, bid, beat counter and address register are all 0.
- awready rises in the first cycle after rst_n deasserts.
- Reset asserted mid-burst aborts the burst with no B response. Beats not yet accepted are never written.

FSM has three states: IDLE, DATA, RESP.

IDLE:
- awready=1.
- On awvalid&awready, latch id, addr, len, size and burst, and clear the beat counter.
- Compute err_cfg, which is 1 if any of the following holds:
  - awburst = WRAP or 11.
  - awsize > calculate_AXI_AXSIZE(AXI_DATA_W).
  - INCR and ({1'b0,aligned_addr[11:0]} + ((awlen+1) << awsize)) > 13'd4096, where aligned_addr is awaddr with its low awsize bits cleared.
- Go to DATA.
- W beats arriving in IDLE are not accepted (wready=0).

DATA:
- mem_valid = wvalid & !err.
- wready = err ? 1 : mem_ready. This is combinational, and valid is never made dependent on ready.
- mem_addr = beat_addr[AXI_ADDR_W-1:OFFSET_W].
- wdata and wstrb pass through unmodified.

Beat accept (wvalid&wready):
- Counter increments.
- For INCR, beat_addr becomes aligned(beat_addr) + (1<<size). The first beat uses the unaligned address, and only its word address matters.
- For FIXED, beat_addr is unchanged.
- The err_last flag is set in either case:
  - wlast=1 while counter<len.
  - wlast=0 on beat counter==len.
- The burst ends on beat len+1 regardless of wlast. Go to RESP.

RESP:
- bvalid=1, bid=latched id.
- bresp = SLVERR if err_cfg|err_last, else OKAY.
- On bready, go to IDLE. awready is 1 in the next cycle, so AW-to-AW spacing is len+3 cycles minimum.
- bvalid and bresp are held stable until bready.

Error bursts:
- Data is still fully consumed, at one beat per cycle, and is never written.
- An early wlast writes that beat and keeps consuming further beats up to len+1.

Boundaries:
- awlen=0 means a single beat.
- awlen=255 means 256 beats; the counter is 8 bits and compares equal to len, so it never wraps.
- An INCR burst ending exactly at a 4KB boundary is OKAY.
- mem_ready low stalls wready with no data loss.

Throughput: one beat per cycle when wvalid and mem_ready are held high.

Decomposition:
- Shared AXI include, already present:
  - calculate_AXI_OFFSET_W and calculate_AXI_AXSIZE.
  - Add localparams AXI_BURST_FIXED/INCR/WRAP and AXI_RESP_OKAY/SLVERR there.
- One natural sub-module, axi_burst_addr_gen:
  - Inputs: start address, size, burst, load, step.
  - Outputs: beat_addr, beat count, last-beat flag, 4K/config error.
  - The future read responder reuses it.

Test Plan:
- INCR, addr 0x100, len 3, size 2, wstrb F, wvalid and mem_ready always high -> mem_addr 0x40, 0x41, 0x42, 0x43 in consecutive cycles; bresp OKAY; bid echoes awid=5.
- Unaligned INCR, addr 0x102, len 1, size 2 -> mem_addr 0x40 then 0x41; wstrb passed unchanged.
- INCR, addr 0xFF8, len 3, size 2 -> crosses 4K; 4 beats accepted; mem_valid never high; bresp SLVERR.
- FIXED, addr 0x20, len 2 -> three writes all to mem_addr 0x08; OKAY.
- wlast early on beat 1 of a len=3 burst -> beats 0-3 accepted; SLVERR. Same burst with mem_ready toggling 1,0 -> wready tracks mem_ready; exactly 4 writes.
- Assert rst_n low after beat 1 of a len=7 burst -> all outputs 0 asynchronously; no bvalid afterwards; the next AW is accepted normally with OKAY.
